// File: rtl/mux_out_deser.sv
// mux_out_deser: samples a single-bit mux output every SAMPLE_DIV cycles,
// shifts the samples MSB-first into a WIDTH-bit word, and presents each
// completed word on a valid/ready handshake with a sticky overrun flag.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   start        one-cycle capture request (honoured only when idle)
//   continuous   1 = capture back-to-back words, 0 = one word then idle
//   bit_in       serial bit being sampled
//   ready        downstream accepts word_out when valid & ready
//   clear_ovr    synchronous clear of overrun
//   word_out     last completed word, first sample in the MSB
//   valid        word_out holds an unconsumed word
//   busy         capture in progress
//   overrun      sticky: a completed word was dropped under backpressure
module mux_out_deser #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_DIV = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             bit_in,
    input  logic             ready,
    input  logic             clear_ovr,
    output logic [WIDTH-1:0] word_out,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    localparam int              BW       = $clog2(WIDTH + 1);
    localparam logic [7:0]      DIV_LOAD = 8'(SAMPLE_DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CAPTURE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] next_word;
    logic             sample;
    logic             complete;
    logic             drop;

    assign sample    = (state == CAPTURE) && (div_cnt == 8'd0);
    assign complete  = sample && (bit_cnt == LAST_BIT);
    assign next_word = {shift[WIDTH-2:0], bit_in};
    // A finished word with the previous one still unconsumed is lost.
    assign drop      = complete && valid && !ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (complete && !continuous) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 8'd0;
            bit_cnt <= '0;
            shift   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                div_cnt <= DIV_LOAD;
                bit_cnt <= '0;
                shift   <= '0;
            end
        end else if (sample) begin
            shift   <= next_word;
            div_cnt <= DIV_LOAD;
            bit_cnt <= complete ? '0 : bit_cnt + BW'(1);
        end else begin
            div_cnt <= div_cnt - 8'd1;
        end
    end

    // A completion with ready=1 replaces the word being consumed, so
    // valid stays high without flagging an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_out <= '0;
            valid    <= 1'b0;
        end else if (complete && !drop) begin
            word_out <= next_word;
            valid    <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_out_deser.sv
// Bench for mux_out_deser: two instances (8-bit/div 5 and 4-bit/div 1)
// checked every cycle against a behavioural model plus literal checks.
module tb_mux_out_deser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       bit_in = 1'b0;
    logic       ready = 1'b0;
    logic       clear_ovr = 1'b0;
    logic [7:0] word_a;
    logic       valid_a, busy_a, ovr_a;
    logic [3:0] word_b;
    logic       valid_b, busy_b, ovr_b;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    mux_out_deser #(.WIDTH(8), .SAMPLE_DIV(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(cont),
        .bit_in(bit_in), .ready(ready), .clear_ovr(clear_ovr),
        .word_out(word_a), .valid(valid_a), .busy(busy_a), .overrun(ovr_a)
    );

    mux_out_deser #(.WIDTH(4), .SAMPLE_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(cont),
        .bit_in(bit_in), .ready(ready), .clear_ovr(clear_ovr),
        .word_out(word_b), .valid(valid_b), .busy(busy_b), .overrun(ovr_b)
    );

    // Model: time since the word began; sample k lands at phase k*SD.
    typedef struct {
        bit          cap;
        int          phase;
        logic [31:0] acc;
        logic [31:0] word;
        bit          valid;
        bit          ovr;
    } m_t;

    m_t ma = '{default: 0};
    m_t mb = '{default: 0};

    function automatic m_t step(m_t s, int w, int sd, logic st, logic cn,
                                logic bi, logic rdy, logic clr);
        m_t          n = s;
        bit          comp = 0;
        bit          lost;
        logic [31:0] nw = 0;
        if (s.cap) begin
            n.phase = s.phase + 1;
            if (n.phase % sd == 0) n.acc = (n.acc << 1) | {31'd0, bi};
            if (n.phase == w * sd) begin
                comp = 1;
                nw = n.acc & ((32'd1 << w) - 32'd1);
                n.phase = 0;
                n.acc = 0;
                n.cap = cn;
            end
        end else if (st) begin
            n.cap = 1;
            n.phase = 0;
            n.acc = 0;
        end
        lost = comp && s.valid && !rdy;
        if (comp && !lost) begin
            n.word = nw;
            n.valid = 1;
        end else if (s.valid && rdy) begin
            n.valid = 0;
        end
        if (lost) n.ovr = 1;
        else if (clr) n.ovr = 0;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = step(ma, 8, 5, start, cont, bit_in, ready, clear_ovr);
            mb = step(mb, 4, 1, start, cont, bit_in, ready, clear_ovr);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_word", {24'd0, word_a}, ma.word);
            check("a_valid", {31'd0, valid_a}, {31'd0, ma.valid});
            check("a_busy", {31'd0, busy_a}, {31'd0, ma.cap});
            check("a_ovr", {31'd0, ovr_a}, {31'd0, ma.ovr});
            check("b_word", {28'd0, word_b}, mb.word);
            check("b_valid", {31'd0, valid_b}, {31'd0, mb.valid});
            check("b_busy", {31'd0, busy_b}, {31'd0, mb.cap});
            check("b_ovr", {31'd0, ovr_b}, {31'd0, mb.ovr});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        cyc(1);
        check("rst_word", {24'd0, word_a}, 32'h0);
        check("rst_valid", {31'd0, valid_a}, 32'h0);
        check("rst_busy", {31'd0, busy_a}, 32'h0);
        check("rst_ovr", {31'd0, ovr_a}, 32'h0);

        // single word, alternating bits -> 0x55
        ready = 1'b1;
        cont = 1'b0;
        bit_in = 1'b0;
        start = 1'b1;
        for (int j = 1; j <= 45; j++) begin
            cyc(1);
            start = 1'b0;
            bit_in = logic'(((j - 1) / 5) % 2);
            if (j == 40) check("t1_valid40", {31'd0, valid_a}, 32'h0);
            if (j == 41) begin
                check("t1_valid41", {31'd0, valid_a}, 32'h1);
                check("t1_word", {24'd0, word_a}, 32'h55);
                check("t1_busy", {31'd0, busy_a}, 32'h0);
            end
            if (j == 42) check("t1_valid42", {31'd0, valid_a}, 32'h0);
        end

        // ignored restart, then accept on the completion edge
        cont = 1'b1;
        ready = 1'b0;
        bit_in = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 130; j++) begin
            cyc(1);
            start = (j == 12);
            bit_in = (j <= 40);
            ready = (j == 80);
            if (j >= 81) begin
                cont = 1'b0;
                ready = 1'b1;
            end
            if (j == 40) check("t3_valid40", {31'd0, valid_a}, 32'h0);
            if (j == 41) check("t3_word1", {24'd0, word_a}, 32'hFF);
            if (j == 81) begin
                check("t3_word2", {24'd0, word_a}, 32'h00);
                check("t3_valid", {31'd0, valid_a}, 32'h1);
                check("t3_ovr", {31'd0, ovr_a}, 32'h0);
            end
            if (j == 130) check("t3_idle", {31'd0, busy_a}, 32'h0);
        end

        // backpressure and overrun
        cont = 1'b1;
        ready = 1'b0;
        bit_in = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 130; j++) begin
            cyc(1);
            start = 1'b0;
            clear_ovr = (j == 81);
            if (j >= 82) begin
                cont = 1'b0;
                ready = 1'b1;
            end
            if (j == 41) begin
                check("t2_word1", {24'd0, word_a}, 32'hFF);
                check("t2_ovr0", {31'd0, ovr_a}, 32'h0);
            end
            if (j == 81) begin
                check("t2_ovr1", {31'd0, ovr_a}, 32'h1);
                check("t2_held", {24'd0, word_a}, 32'hFF);
                check("t2_valid", {31'd0, valid_a}, 32'h1);
            end
            if (j == 82) check("t2_clr", {31'd0, ovr_a}, 32'h0);
        end

        // async reset mid-capture, then fresh capture
        ready = 1'b1;
        cont = 1'b0;
        start = 1'b1;
        for (int j = 1; j <= 23; j++) begin
            cyc(1);
            start = 1'b0;
            bit_in = logic'($urandom % 2);
        end
        #2 rst_n = 1'b0;
        #1;
        check("t5_word", {24'd0, word_a}, 32'h0);
        check("t5_valid", {31'd0, valid_a}, 32'h0);
        check("t5_busy", {31'd0, busy_a}, 32'h0);
        cyc(3);
        rst_n = 1'b1;
        bit_in = 1'b1;
        start = 1'b1;
        for (int j = 1; j <= 42; j++) begin
            cyc(1);
            start = 1'b0;
            if (j == 40) check("t5_pre", {31'd0, valid_a}, 32'h0);
            if (j == 41) check("t5_fresh", {24'd0, word_a}, 32'hFF);
        end

        // SAMPLE_DIV=1, WIDTH=4: bits 1,0,1,1 -> 0xB
        start = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            start = 1'b0;
            bit_in = (j == 1) || (j == 3) || (j == 4);
            if (j == 4) check("t6_valid4", {31'd0, valid_b}, 32'h0);
            if (j == 5) begin
                check("t6_word", {28'd0, word_b}, 32'hB);
                check("t6_valid5", {31'd0, valid_b}, 32'h1);
            end
        end

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            start = ($urandom % 10) == 0;
            cont = logic'($urandom % 2);
            bit_in = logic'($urandom % 2);
            ready = ($urandom % 3) != 0;
            clear_ovr = ($urandom % 20) == 0;
            if (i % 1000 == 500) begin
                #2 rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
